// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : PC / instruction-memory / decoder signal bundle for fetch_unit
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic [15:0] pcIn;
    logic        fetchStart;
    logic [15:0] memAddr;
    logic        memRead;
    logic        memAck;
    logic [15:0] memData;
    logic [15:0] instr;
    logic        instrValid;
    logic        instrTaken;
    logic [15:0] raOut;
    logic        pcWriteEn;
    logic        busy;
    logic        fetchFault;

    // Fetch-unit side
    modport slave (
        input  pcIn, fetchStart, memAck, memData, instrTaken,
        output memAddr, memRead, instr, instrValid, raOut, pcWriteEn, busy, fetchFault
    );

    // Control / memory / decoder side
    modport master (
        output pcIn, fetchStart, memAck, memData, instrTaken,
        input  memAddr, memRead, instr, instrValid, raOut, pcWriteEn, busy, fetchFault
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-word instruction fetch FSM (IDLE/REQ/VALID/FAULT)
//              Optional macro FETCH_TIMEOUT_EN adds a 16-cycle memory timeout.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit (
    input  logic        clock,
    input  logic        reset,
    fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [15:0] r_instr;
    logic [15:0] r_ra;
    logic        r_memRead;
    logic        r_instrValid;
    logic        r_busy;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  r_toCnt;
    logic        r_fault;
`endif

    logic w_pcWriteEn;
    logic w_launch;

    // Consumption and the back-to-back launch are same-cycle reactions to instrTaken
    assign w_pcWriteEn = (r_state == S_VALID) && bus.instrTaken;
    assign w_launch    = bus.fetchStart && ((r_state == S_IDLE) || w_pcWriteEn);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= 16'h0000;
            r_instr      <= 16'h0000;
            r_ra         <= 16'h0000;
            r_memRead    <= 1'b0;
            r_instrValid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_toCnt      <= 4'd0;
            r_fault      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.memAck) begin
                        r_instr      <= bus.memData;
                        r_instrValid <= 1'b1;
                        r_memRead    <= 1'b0;
                        r_state      <= S_VALID;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Counter holds the number of ack-less REQ cycles already elapsed
                    else if (r_toCnt == 4'hF) begin
                        r_memRead <= 1'b0;
                        r_fault   <= 1'b1;
                        r_state   <= S_FAULT;
                    end else begin
                        r_toCnt <= r_toCnt + 4'd1;
                    end
`endif
                end
                S_VALID: begin
                    if (bus.instrTaken) begin
                        r_instrValid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase

            // A launch overrides the IDLE fall-through of a consumed VALID word
            if (w_launch) begin
                r_addr    <= bus.pcIn;
                r_ra      <= bus.pcIn + 16'd1;
                r_memRead <= 1'b1;
                r_busy    <= 1'b1;
                r_state   <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
                r_toCnt   <= 4'd0;
`endif
            end
        end
    end

    assign bus.memAddr    = r_addr;
    assign bus.memRead    = r_memRead;
    assign bus.instr      = r_instr;
    assign bus.instrValid = r_instrValid;
    assign bus.raOut      = r_ra;
    assign bus.pcWriteEn  = w_pcWriteEn;
    assign bus.busy       = r_busy;
`ifdef FETCH_TIMEOUT_EN
    assign bus.fetchFault = r_fault;
`else
    assign bus.fetchFault = 1'b0;
`endif

endmodule

`default_nettype wire
